// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus between the memory-access stage (master)
// and the data cache (slave).
interface mem_access_unit_if #(
   parameter int XLEN = 64
);
   logic            DCACHE_valid;
   logic [XLEN-1:0] DCACHE_addr;
   logic [XLEN-1:0] DCACHE_wdata;
   logic [7:0]      DCACHE_mask;
   logic            DCACHE_wen;
   logic            DCACHE_valid_out;
   logic [XLEN-1:0] DCACHE_rdata;

   modport master (
      output DCACHE_valid, DCACHE_addr, DCACHE_wdata, DCACHE_mask, DCACHE_wen,
      input  DCACHE_valid_out, DCACHE_rdata
   );

   modport slave (
      input  DCACHE_valid, DCACHE_addr, DCACHE_wdata, DCACHE_mask, DCACHE_wen,
      output DCACHE_valid_out, DCACHE_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: checks alignment, issues one data-cache request per
// load/store, extends load data and hands the result to write-back.
module mem_access_unit #(
   parameter int XLEN           = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_is_mem,
   input  logic                in_is_store,
   input  logic [2:0]          in_funct3,
   input  logic [XLEN-1:0]     in_addr,
   input  logic [XLEN-1:0]     in_wdata,
   input  logic [XLEN-1:0]     in_result,
   input  logic [4:0]          in_rd,
   input  logic                in_rd_wen,

   mem_access_unit_if.master   dcache,

   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_data,
   output logic [4:0]          out_rd,
   output logic                out_rd_wen,
   output logic                out_misalign,
   output logic                out_bus_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              is_store_q, is_store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              rd_wen_q, rd_wen_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_data_q, out_data_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              out_rd_wen_q, out_rd_wen_d;
   logic              out_misalign_q, out_misalign_d;
   logic              out_bus_err_q, out_bus_err_d;

   function automatic logic misaligned(input logic [2:0] f3, input logic [XLEN-1:0] a);
      case (f3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = a[0];
         2'b10:   misaligned = |a[1:0];
         default: misaligned = |a[2:0];
      endcase
   endfunction

   function automatic logic [7:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // funct3 111 has no defined meaning and falls through to doubleword
   function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] r);
      case (f3)
         3'b000:  extend = {{(XLEN-8){r[7]}}, r[7:0]};
         3'b001:  extend = {{(XLEN-16){r[15]}}, r[15:0]};
         3'b010:  extend = {{(XLEN-32){r[31]}}, r[31:0]};
         3'b100:  extend = {{(XLEN-8){1'b0}}, r[7:0]};
         3'b101:  extend = {{(XLEN-16){1'b0}}, r[15:0]};
         3'b110:  extend = {{(XLEN-32){1'b0}}, r[31:0]};
         default: extend = r;
      endcase
   endfunction

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_store_d     = is_store_q;
      funct3_d       = funct3_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rd_wen_d       = rd_wen_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_rd_d       = out_rd_q;
      out_rd_wen_d   = out_rd_wen_q;
      out_misalign_d = out_misalign_q;
      out_bus_err_d  = out_bus_err_q;

      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (in_valid) begin
               is_store_d     = in_is_store;
               funct3_d       = in_funct3;
               addr_d         = in_addr;
               wdata_d        = in_wdata;
               rd_wen_d       = in_rd_wen;
               out_rd_d       = in_rd;
               out_data_d     = '0;
               out_rd_wen_d   = 1'b0;
               out_misalign_d = 1'b0;
               out_bus_err_d  = 1'b0;
               if (!in_is_mem) begin
                  state_d      = RESP;
                  out_valid_d  = 1'b1;
                  out_data_d   = in_result;
                  out_rd_wen_d = in_rd_wen;
               end else if (misaligned(in_funct3, in_addr)) begin
                  state_d        = RESP;
                  out_valid_d    = 1'b1;
                  out_misalign_d = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + 8'd1;
            // A completion on the final permitted cycle still counts as success
            if (dcache.DCACHE_valid_out) begin
               state_d     = RESP;
               cnt_d       = 8'd0;
               out_valid_d = 1'b1;
               if (is_store_q) begin
                  out_data_d   = '0;
                  out_rd_wen_d = 1'b0;
               end else begin
                  out_data_d   = extend(funct3_q, dcache.DCACHE_rdata);
                  out_rd_wen_d = rd_wen_q;
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d       = RESP;
               cnt_d         = 8'd0;
               out_valid_d   = 1'b1;
               out_data_d    = '0;
               out_rd_wen_d  = 1'b0;
               out_bus_err_d = 1'b1;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_d        = IDLE;
               out_valid_d    = 1'b0;
               out_data_d     = '0;
               out_rd_d       = 5'd0;
               out_rd_wen_d   = 1'b0;
               out_misalign_d = 1'b0;
               out_bus_err_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= 8'd0;
         is_store_q     <= 1'b0;
         funct3_q       <= 3'd0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rd_wen_q       <= 1'b0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_rd_q       <= 5'd0;
         out_rd_wen_q   <= 1'b0;
         out_misalign_q <= 1'b0;
         out_bus_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_store_q     <= is_store_d;
         funct3_q       <= funct3_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rd_wen_q       <= rd_wen_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_rd_q       <= out_rd_d;
         out_rd_wen_q   <= out_rd_wen_d;
         out_misalign_q <= out_misalign_d;
         out_bus_err_q  <= out_bus_err_d;
      end
   end

   // Request lines decode straight off state_q so they drop the cycle after
   // completion and asynchronously on reset.
   always_comb begin
      dcache.DCACHE_valid = (state_q == REQ);
      dcache.DCACHE_addr  = (state_q == REQ) ? addr_q : '0;
      dcache.DCACHE_wdata = (state_q == REQ) ? wdata_q : '0;
      dcache.DCACHE_mask  = (state_q == REQ) ? size_mask(funct3_q) : 8'h00;
      dcache.DCACHE_wen   = (state_q == REQ) && is_store_q;
   end

   assign in_ready     = (state_q == IDLE) && rst;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_rd       = out_rd_q;
   assign out_rd_wen   = out_rd_wen_q;
   assign out_misalign = out_misalign_q;
   assign out_bus_err  = out_bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a behavioural model of the
// alignment, mask, extension, latency and timeout rules.
module tb_mem_access_unit;

   localparam int XLEN = 64;
   localparam int TO   = 4;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic            in_is_mem;
   logic            in_is_store;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_addr;
   logic [XLEN-1:0] in_wdata;
   logic [XLEN-1:0] in_result;
   logic [4:0]      in_rd;
   logic            in_rd_wen;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [4:0]      out_rd;
   logic            out_rd_wen;
   logic            out_misalign;
   logic            out_bus_err;

   int checkCount = 0;
   int errorCount = 0;

   mem_access_unit_if #(.XLEN(XLEN)) dc ();

   mem_access_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_is_mem    (in_is_mem),
      .in_is_store  (in_is_store),
      .in_funct3    (in_funct3),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_result    (in_result),
      .in_rd        (in_rd),
      .in_rd_wen    (in_rd_wen),
      .dcache       (dc.master),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_rd       (out_rd),
      .out_rd_wen   (out_rd_wen),
      .out_misalign (out_misalign),
      .out_bus_err  (out_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // lat = REQ cycles before the one in which the cache pulses valid_out
   task automatic applyStimulus(input logic isMem, input logic isStore, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] result, input logic [4:0] rd,
                                input logic rdWen, input int lat, input logic [63:0] rdata,
                                input int stall);
      int bytes;
      int bits;
      logic misal;
      logic [7:0] expMask;
      logic [63:0] expData;
      logic expWen;
      logic expErr;
      logic signed [63:0] tmp;
      int expReq;
      int expCyc;
      int cyc;
      int reqCycles;
      logic seenOut;

      bytes   = 1 << f3[1:0];
      bits    = bytes * 8;
      misal   = isMem && ((addr % 64'(bytes)) != 0);
      expMask = 8'((16'd1 << bytes) - 16'd1);
      expErr  = 1'b0;
      expReq  = 0;
      if (!isMem) begin
         expData = result;
         expWen  = rdWen;
      end else if (misal) begin
         expData = 0;
         expWen  = 1'b0;
      end else begin
         if (lat + 1 <= TO) expReq = lat + 1;
         else begin
            expReq = TO;
            expErr = 1'b1;
         end
         if (isStore || expErr) begin
            expData = 0;
            expWen  = 1'b0;
         end else begin
            if (bits == 64) expData = rdata;
            else if (f3[2]) expData = rdata & ((64'd1 << bits) - 64'd1);
            else begin
               tmp     = rdata << (64 - bits);
               tmp     = tmp >>> (64 - bits);
               expData = tmp;
            end
            expWen = rdWen;
         end
      end
      expCyc = expReq + 1;

      @(negedge clk);
      in_valid    = 1'b1;
      in_is_mem   = isMem;
      in_is_store = isStore;
      in_funct3   = f3;
      in_addr     = addr;
      in_wdata    = wdata;
      in_result   = result;
      in_rd       = rd;
      in_rd_wen   = rdWen;
      checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_addr   = {$urandom, $urandom};
      in_result = {$urandom, $urandom};
      cyc       = 1;
      reqCycles = 0;
      seenOut   = 1'b0;
      while (!seenOut && cyc <= 20) begin
         dc.DCACHE_valid_out = 1'b0;
         dc.DCACHE_rdata     = {$urandom, $urandom};
         if (dc.DCACHE_valid) begin
            reqCycles++;
            checkOutput("dc_addr", dc.DCACHE_addr, addr);
            checkOutput("dc_mask", 64'(dc.DCACHE_mask), 64'(expMask));
            checkOutput("dc_wen", 64'(dc.DCACHE_wen), 64'(isStore));
            checkOutput("dc_wdata", dc.DCACHE_wdata, wdata);
            checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
            if (reqCycles == lat + 1) begin
               dc.DCACHE_valid_out = 1'b1;
               dc.DCACHE_rdata     = rdata;
            end
         end
         if (out_valid) seenOut = 1'b1;
         else begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
         end
      end
      dc.DCACHE_valid_out = 1'b0;
      checkOutput("out_valid_seen", 64'(seenOut), 64'd1);
      checkOutput("latency", 64'(cyc), 64'(expCyc));
      checkOutput("req_cycles", 64'(reqCycles), 64'(expReq));

      for (int s = 0; s <= stall; s++) begin
         checkOutput("out_valid", 64'(out_valid), 64'd1);
         checkOutput("out_data", out_data, expData);
         checkOutput("out_rd", 64'(out_rd), 64'(rd));
         checkOutput("out_rd_wen", 64'(out_rd_wen), 64'(expWen));
         checkOutput("out_misalign", 64'(out_misalign), 64'(misal));
         checkOutput("out_bus_err", 64'(out_bus_err), 64'(expErr));
         checkOutput("dc_valid_resp", 64'(dc.DCACHE_valid), 64'd0);
         checkOutput("in_ready_resp", 64'(in_ready), 64'd0);
         if (s == stall) out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput("out_valid_clear", 64'(out_valid), 64'd0);
      checkOutput("flags_clear", 64'({out_misalign, out_bus_err}), 64'd0);
      checkOutput("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst                 = 1'b0;
      in_valid            = 1'b0;
      in_is_mem           = 1'b0;
      in_is_store         = 1'b0;
      in_funct3           = 3'd0;
      in_addr             = '0;
      in_wdata            = '0;
      in_result           = '0;
      in_rd               = 5'd0;
      in_rd_wen           = 1'b0;
      out_ready           = 1'b0;
      dc.DCACHE_valid_out = 1'b0;
      dc.DCACHE_rdata     = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", out_data, 64'd0);
      checkOutput("rst_dc_valid", 64'(dc.DCACHE_valid), 64'd0);
      checkOutput("rst_dc_addr", dc.DCACHE_addr, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

      // lb, lwu, lw, sd, misaligned lh, miss with stall, timeout, ALU op
      applyStimulus(1, 0, 3'b000, 64'h8000_0010, 64'h0, 64'h0, 5'd3, 1, 1, 64'h0000_0000_0000_0080, 0);
      applyStimulus(1, 0, 3'b110, 64'h8000_0010, 64'h0, 64'h0, 5'd4, 1, 1, 64'h0000_0000_8000_0001, 0);
      applyStimulus(1, 0, 3'b010, 64'h8000_0010, 64'h0, 64'h0, 5'd5, 1, 1, 64'h0000_0000_8000_0001, 0);
      applyStimulus(1, 1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 5'd6, 1, 1, 64'h0, 0);
      applyStimulus(1, 0, 3'b001, 64'h8000_0003, 64'h0, 64'h0, 5'd7, 1, 1, 64'h0, 0);
      applyStimulus(1, 0, 3'b011, 64'h8000_0020, 64'h0, 64'h0, 5'd8, 1, 2, 64'hDEAD_BEEF_0123_4567, 3);
      applyStimulus(1, 0, 3'b010, 64'h8000_0040, 64'h0, 64'h0, 5'd9, 1, 99, 64'h0, 1);
      applyStimulus(1, 0, 3'b111, 64'h8000_0048, 64'h0, 64'h0, 5'd10, 1, TO - 1, 64'hCAFE_F00D_1234_5678, 0);
      applyStimulus(0, 0, 3'b000, 64'h0000_0001, 64'h0, 64'hA5A5_0000_1111_2222, 5'd11, 1, 0, 64'h0, 2);

      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom),
                       64'h8000_0000 + 64'($urandom_range(0, 255)),
                       {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                       1'($urandom), $urandom_range(0, 5), {$urandom, $urandom},
                       $urandom_range(0, 3));
      end

      // reset while a request is outstanding
      @(negedge clk);
      in_valid  = 1'b1;
      in_is_mem = 1'b1;
      in_is_store = 1'b0;
      in_funct3 = 3'b011;
      in_addr   = 64'h8000_0100;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreq_dc_valid", 64'(dc.DCACHE_valid), 64'd1);
      rst = 1'b0;
      #1;
      checkOutput("midreq_rst_dc_valid", 64'(dc.DCACHE_valid), 64'd0);
      checkOutput("midreq_rst_dc_addr", dc.DCACHE_addr, 64'd0);
      checkOutput("midreq_rst_dc_mask", 64'(dc.DCACHE_mask), 64'd0);
      checkOutput("midreq_rst_out", 64'({out_valid, out_rd_wen, out_misalign, out_bus_err}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("post_rst_dc_valid", 64'(dc.DCACHE_valid), 64'd0);
      checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
